// File: rtl/mux4x2_ctl_pkg.sv
// mux4x2_ctl_pkg
//   Shared definitions for the 4-in / 2-out ring mux controller:
//   select width and encodings driven onto the datapath mux, the
//   grant-source type used per output, and a one-hot to index helper.
package mux4x2_ctl_pkg;

  localparam int SEL_W = 3;

  // Select values 0..3 address a ring port directly.
  localparam logic [SEL_W-1:0] SEL_LOCAL = 3'd4;
  localparam logic [SEL_W-1:0] SEL_IDLE  = 3'd7;

  typedef enum logic [1:0] {
    SRC_IDLE  = 2'd0,
    SRC_RING  = 2'd1,
    SRC_LOCAL = 2'd2
  } grant_src_e;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[3])      idx = 2'd3;
    else if (oh[2]) idx = 2'd2;
    else if (oh[1]) idx = 2'd1;
    return idx;
  endfunction

endpackage

// File: rtl/mux4x2_ctl_rr_arb4.sv
// rr_arb4
//   Purely combinational 4-way round-robin picker. Searches the request
//   vector starting at ptr and wrapping; returns a one-hot winner.
// Ports:
//   req  in  4  request vector
//   ptr  in  2  highest-priority index this cycle
//   gnt  out 4  one-hot winner (zero when no request)
//   any  out 1  at least one request present
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = 4'b0000;
    found = 1'b0;
    idx   = 2'd0;
    for (int n = 0; n < 4; n++) begin
      idx = ptr + 2'(n);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4x2_ctl.sv
// mux4x2_ctl
//   Grant controller for a 4-input ring mux with two outputs. Each output
//   picks among the ring ports addressed to it (round-robin) and a local
//   injector; a local injector that has been denied STARVE_LIMIT cycles in
//   a row takes top priority. Decisions are combinational (zero latency to
//   the datapath mux); only round-robin pointers and starvation counters
//   are registered.
// Ports:
//   clk         in   1  clock, rising edge
//   rst         in   1  asynchronous reset, active low
//   req_i       in   4  ring port i holds a flit
//   dst_i       in   4  ring port i destination (0 = out0, 1 = out1)
//   linj_req_i  in   2  local injector k requests output k
//   out_rdy_i   in   2  output k downstream can accept
//   gnt_o       out  4  ring port i granted this cycle
//   linj_gnt_o  out  2  local injector k granted this cycle
//   sel0_o      out  3  out0 mux select (0..3 ring, 4 local, 7 idle)
//   sel1_o      out  3  out1 mux select
//   out_vld_o   out  2  output k carries a valid flit
module mux4x2_ctl
  import mux4x2_ctl_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CTR_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_i,
  input  logic [3:0]       dst_i,
  input  logic [1:0]       linj_req_i,
  input  logic [1:0]       out_rdy_i,
  output logic [3:0]       gnt_o,
  output logic [1:0]       linj_gnt_o,
  output logic [SEL_W-1:0] sel0_o,
  output logic [SEL_W-1:0] sel1_o,
  output logic [1:0]       out_vld_o
);

  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(STARVE_LIMIT);

  logic [1:0][3:0]       ring_gnt;
  logic [1:0][SEL_W-1:0] sel;

  for (genvar k = 0; k < 2; k++) begin : g_out
    logic [1:0]       ptr_q;
    logic [CTR_W-1:0] cnt_q;
    logic [3:0]       cand;
    logic [3:0]       win;
    logic             any;
    grant_src_e       src;

    // dst selects exactly one output per port, so the two candidate sets
    // are disjoint and a port can never be granted on both outputs.
    assign cand = (k == 0) ? (req_i & ~dst_i) : (req_i & dst_i);

    rr_arb4 u_arb (
      .req (cand),
      .ptr (ptr_q),
      .gnt (win),
      .any (any)
    );

    // Reset forces idle combinationally so grants drop in the same cycle.
    always_comb begin
      src = SRC_IDLE;
      if (rst && out_rdy_i[k]) begin
        if (linj_req_i[k] && (cnt_q == LIMIT)) src = SRC_LOCAL;
        else if (any)                          src = SRC_RING;
        else if (linj_req_i[k])                src = SRC_LOCAL;
      end
    end

    always_comb begin
      ring_gnt[k]   = 4'b0000;
      sel[k]        = SEL_IDLE;
      linj_gnt_o[k] = 1'b0;
      out_vld_o[k]  = 1'b0;
      case (src)
        SRC_RING: begin
          ring_gnt[k]  = win;
          sel[k]       = {1'b0, oh2idx(win)};
          out_vld_o[k] = 1'b1;
        end
        SRC_LOCAL: begin
          sel[k]        = SEL_LOCAL;
          linj_gnt_o[k] = 1'b1;
          out_vld_o[k]  = 1'b1;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ptr_q <= 2'd0;
        cnt_q <= '0;
      end else begin
        if (src == SRC_RING) ptr_q <= oh2idx(win) + 2'd1;

        // A withdrawn request ends the starvation episode even while the
        // output is stalled; otherwise a stall freezes the count.
        if (!linj_req_i[k])          cnt_q <= '0;
        else if (!out_rdy_i[k])      cnt_q <= cnt_q;
        else if (src == SRC_LOCAL)   cnt_q <= '0;
        else if (cnt_q != LIMIT)     cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign gnt_o  = ring_gnt[0] | ring_gnt[1];
  assign sel0_o = sel[0];
  assign sel1_o = sel[1];

endmodule

// File: tb/tb_mux4x2_ctl.sv
module tb_mux4x2_ctl;

  localparam int LIMIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i, dst_i;
  logic [1:0] linj_req_i, out_rdy_i;
  logic [3:0] gnt_o;
  logic [1:0] linj_gnt_o, out_vld_o;
  logic [2:0] sel0_o, sel1_o;

  mux4x2_ctl #(.STARVE_LIMIT(LIMIT), .CTR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .dst_i      (dst_i),
    .linj_req_i (linj_req_i),
    .out_rdy_i  (out_rdy_i),
    .gnt_o      (gnt_o),
    .linj_gnt_o (linj_gnt_o),
    .sel0_o     (sel0_o),
    .sel1_o     (sel1_o),
    .out_vld_o  (out_vld_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] lg;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [1:0] vld;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // reference model state
  int   m_ptr[2];
  int   m_cnt[2];
  int   e_ring[2];   // ring port granted on output k this cycle, -1 none
  bit   e_local[2];
  exp_t e_cur;
  bit   p_rst;
  bit [1:0] p_linj, p_rdy;

  function automatic void chk(string name, int act, int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      m_cnt[k] = 0;
      e_ring[k] = -1;
      e_local[k] = 0;
    end
  endtask

  // State change implied by the decisions of the cycle just ended.
  task automatic model_advance();
    if (!p_rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (e_ring[k] >= 0) m_ptr[k] = (e_ring[k] + 1) % 4;
      if (!p_linj[k])      m_cnt[k] = 0;
      else if (!p_rdy[k])  ;
      else if (e_local[k]) m_cnt[k] = 0;
      else if (m_cnt[k] < LIMIT) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic model_eval();
    int sel[2];
    e_cur = '0;
    for (int k = 0; k < 2; k++) begin
      e_ring[k] = -1;
      e_local[k] = 0;
      sel[k] = 7;
      if (rst && out_rdy_i[k]) begin
        if (linj_req_i[k] && m_cnt[k] == LIMIT) e_local[k] = 1;
        else begin
          for (int n = 0; n < 4; n++) begin
            int p;
            p = (m_ptr[k] + n) % 4;
            if (e_ring[k] < 0 && req_i[p] && int'(dst_i[p]) == k) e_ring[k] = p;
          end
          if (e_ring[k] < 0 && linj_req_i[k]) e_local[k] = 1;
        end
      end
      if (e_ring[k] >= 0) begin
        sel[k] = e_ring[k];
        e_cur.gnt[e_ring[k]] = 1'b1;
        e_cur.vld[k] = 1'b1;
      end else if (e_local[k]) begin
        sel[k] = 4;
        e_cur.lg[k] = 1'b1;
        e_cur.vld[k] = 1'b1;
      end
    end
    e_cur.s0 = 3'(sel[0]);
    e_cur.s1 = 3'(sel[1]);
  endtask

  // One clock of stimulus: advance model, drive, predict, enqueue.
  task automatic cycle(input bit r, input logic [3:0] rq, input logic [3:0] ds,
                       input logic [1:0] lj, input logic [1:0] rd);
    @(posedge clk);
    #1;
    model_advance();
    rst = r; req_i = rq; dst_i = ds; linj_req_i = lj; out_rdy_i = rd;
    model_eval();
    q.push_back(e_cur);
    p_rst = r; p_linj = lj; p_rdy = rd;
    #1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_gnt",  int'(gnt_o),      int'(e.gnt));
        chk("sb_lgnt", int'(linj_gnt_o), int'(e.lg));
        chk("sb_sel0", int'(sel0_o),     int'(e.s0));
        chk("sb_sel1", int'(sel1_o),     int'(e.s1));
        chk("sb_vld",  int'(out_vld_o),  int'(e.vld));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rr_req[5];
    logic [3:0] cur_req, cur_dst;
    rr_req[0] = 4'b1111; rr_req[1] = 4'b1110; rr_req[2] = 4'b1101;
    rr_req[3] = 4'b1011; rr_req[4] = 4'b0111;

    rst = 1'b0; req_i = '0; dst_i = '0; linj_req_i = '0; out_rdy_i = '0;
    p_rst = 0; p_linj = 0; p_rdy = 0;
    model_reset();

    // reset with everything requesting
    cycle(0, 4'b1111, 4'b0101, 2'b11, 2'b11);
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_sel0", int'(sel0_o), 7);
    chk("rst_sel1", int'(sel1_o), 7);
    chk("rst_vld", int'(out_vld_o), 0);
    chk("rst_lgnt", int'(linj_gnt_o), 0);
    cycle(0, 4'b1111, 4'b0000, 2'b00, 2'b11);

    // round robin on out0
    for (int c = 0; c < 5; c++) begin
      cycle(1, rr_req[c], 4'b0000, 2'b00, 2'b11);
      chk("rr_gnt", int'(gnt_o), 1 << (c % 4));
      chk("rr_sel0", int'(sel0_o), c % 4);
      chk("rr_sel1", int'(sel1_o), 7);
    end

    // mid-operation reset during round robin
    cycle(0, 4'b0000, 4'b0000, 2'b00, 2'b11);
    cycle(1, rr_req[0], 4'b0000, 2'b00, 2'b11);
    cycle(1, rr_req[1], 4'b0000, 2'b00, 2'b11);
    cycle(0, rr_req[2], 4'b0000, 2'b00, 2'b11);
    chk("midrst_gnt", int'(gnt_o), 0);
    chk("midrst_vld", int'(out_vld_o), 0);
    cycle(1, 4'b1111, 4'b0000, 2'b00, 2'b11);
    chk("midrst_first", int'(gnt_o), 1);

    // dual output
    cycle(1, 4'b0110, 4'b0100, 2'b00, 2'b11);
    chk("dual_gnt", int'(gnt_o), 6);
    chk("dual_sel0", int'(sel0_o), 1);
    chk("dual_sel1", int'(sel1_o), 2);
    chk("dual_vld", int'(out_vld_o), 3);

    // starvation of local injector 0
    cycle(0, 4'b0000, 4'b0000, 2'b00, 2'b11);
    for (int c = 1; c <= 12; c++) begin
      cycle(1, 4'b0001, 4'b0000, 2'b01, 2'b11);
      chk("starve_lgnt", int'(linj_gnt_o), (c == 9) ? 1 : 0);
      chk("starve_sel0", int'(sel0_o), (c == 9) ? 4 : 0);
    end

    // back-pressure freezes the counter
    cycle(0, 4'b0000, 4'b0000, 2'b00, 2'b11);
    for (int c = 0; c < 5; c++) cycle(1, 4'b0001, 4'b0000, 2'b01, 2'b11);
    for (int c = 0; c < 5; c++) begin
      cycle(1, 4'b0001, 4'b0000, 2'b01, 2'b10);
      chk("bp_gnt", int'(gnt_o), 0);
      chk("bp_sel0", int'(sel0_o), 7);
    end
    for (int c = 0; c < 4; c++) begin
      cycle(1, 4'b0001, 4'b0000, 2'b01, 2'b11);
      chk("bp_resume_gnt", int'(gnt_o), (c < 3) ? 1 : 0);
      chk("bp_resume_lgnt", int'(linj_gnt_o), (c < 3) ? 0 : 1);
    end

    // randomized legal traffic
    cur_req = '0; cur_dst = '0;
    for (int c = 0; c < 800; c++) begin
      bit r;
      for (int i = 0; i < 4; i++) begin
        if (cur_req[i] && !e_cur.gnt[i] && p_rst) begin
          if ($urandom_range(7) == 0) cur_req[i] = 1'b0;
        end else begin
          cur_req[i] = ($urandom_range(3) != 0);
          cur_dst[i] = 1'($urandom_range(1));
        end
      end
      r = ($urandom_range(63) != 0);
      cycle(r, cur_req, cur_dst, 2'($urandom_range(3)),
            ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b11);
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4x2_ctl.md
MUX4X2_CTL -- requirements
Module: mux4x2_ctl

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive denied cycles after which a local injector gets top priority.
REQ-002 Parameter CTR_W, default 4: starvation counter width; it SHALL satisfy 2^CTR_W > STARVE_LIMIT.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_i  in  4  ring port i (0..3) holds a flit for the mux.
REQ-006 dst_i  in  4  bit i selects the requested output for port i: 0 = out0, 1 = out1.
REQ-007 linj_req_i  in  2  local injector k requests output k.
REQ-008 out_rdy_i  in  2  downstream of output k can accept a flit this cycle.
REQ-009 gnt_o  out  4  ring port i granted; the flit transfers this cycle.
REQ-010 linj_gnt_o  out  2  local injector k granted.
REQ-011 sel0_o, sel1_o  out  3 each  mux selects: 0..3 = ring port, 4 = local, 7 = idle.
REQ-012 out_vld_o  out  2  output k carries a valid flit this cycle.

Function
REQ-013 Grants, selects and valids SHALL be combinational from inputs and registered state, giving zero-cycle latency to the datapath mux.
REQ-014 Output k candidates SHALL be ring ports i with req_i[i]=1 and dst_i[i]=k.
REQ-015 If out_rdy_i[k]=0: no grant for output k, sel=7, out_vld_o[k]=0, and no pointer change.
REQ-016 Priority for output k SHALL be: (1) local when linj_req_i[k]=1 and cnt[k]=STARVE_LIMIT; (2) ring candidate chosen round-robin starting at ptr[k]; (3) local; (4) idle with sel=7.
REQ-017 A ring port SHALL be granted to at most one output per cycle; gnt_o[i]=1 only with sel(dst_i[i])=i.
REQ-018 On a ring grant to port w on output k, ptr[k] SHALL become (w+1) mod 4; otherwise ptr[k] holds.
REQ-019 cnt[k] SHALL increment, saturating at STARVE_LIMIT, when linj_req_i[k]=1, out_rdy_i[k]=1 and linj_gnt_o[k]=0.
REQ-020 cnt[k] SHALL clear on linj_gnt_o[k]=1 or when linj_req_i[k]=0, and hold when out_rdy_i[k]=0.
REQ-021 out_vld_o[k] SHALL be 1 iff any grant targets output k.
REQ-022 A requester SHALL hold req and dst stable until granted; a drop without a grant is legal and takes effect immediately.
REQ-023 Both outputs SHALL be arbitrated independently in the same cycle, with no coupling except the per-port exclusivity of REQ-017.

Reset
REQ-024 While rst=0: ptr[0..1]=0, cnt[0..1]=0, gnt_o=0, linj_gnt_o=0, out_vld_o=0, sel0_o=sel1_o=7, regardless of other inputs.
REQ-025 Reset asserted mid-operation SHALL drop all grants in the same cycle; arbitration restarts from the reset state on the first edge after release.

Structure
REQ-026 Select encodings (SEL_LOCAL=4, SEL_IDLE=7) and the 3-bit select width SHALL live in the shared defines file used by the mux.
REQ-027 One sub-module, rr_arb4, SHALL be used: a 4-way round-robin picker (request vector, pointer -> one-hot winner, any), instantiated once per output.
REQ-028 The controller SHALL own the pointer and counter registers; rr_arb4 SHALL be purely combinational.

Verification
REQ-029 Reset: rst=0 with all requests high -> all grants 0, sel=7/7, out_vld=00; after release with ptr=0, req=1111 and dst=0000 -> gnt=0001, sel0=0.
REQ-030 Round-robin: req=1111 and dst=0000 held; port i drops req the cycle after its grant and reasserts the next cycle -> out0 grants ports 0,1,2,3,0 on successive cycles; sel1=7 throughout.
REQ-031 Dual output: req=0110, dst=0100 -> gnt=0110 in one cycle, sel0=1, sel1=2, out_vld=11.
REQ-032 Starvation: linj_req=01, req=0001 and dst=0000 held for 12 cycles -> local denied for 8 cycles, granted on cycle 9 with sel0=4; cnt clears.
REQ-033 Back-pressure: out_rdy=10 with port 0 requesting out0 -> gnt=0, sel0=7; ptr and cnt unchanged; grant occurs the first cycle out_rdy[0]=1.
REQ-034 Mid-op reset: rst=0 for one cycle during REQ-030 -> grants drop the same cycle; the first post-reset grant goes to port 0.
